// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - CPU request/response and data-memory port bundle for store_buffer
interface store_buffer_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_we;
    logic          cpu_re;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          stall;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_rdata, stall, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_rdata, stall, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write FIFO in front of a single-port data memory
// Optional feature: define STORE_BUF_FWD_EN to forward pending store data to matching loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    store_buffer_if.slave                bus,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;

    logic          full_q;
    logic          empty_q;
    logic          hit;
    logic [DW-1:0] hit_data;
    logic          fwd;
    logic          load_stall;
    logic          store_stall;
    logic          load_port;
    logic          enq;
    logic          drain;

    assign full_q  = (cnt == CW'(DEPTH));
    assign empty_q = (cnt == '0);

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < cnt && addr_q[head + PW'(k)] == bus.cpu_addr) begin
                hit      = bus.cpu_re;
                hit_data = data_q[head + PW'(k)];
            end
        end
    end

`ifdef STORE_BUF_FWD_EN
    assign fwd        = hit;
    assign load_stall = bus.cpu_re && !hit && full_q;
`else
    assign fwd        = 1'b0;
    assign load_stall = bus.cpu_re && (hit || full_q);
`endif

    assign load_port   = bus.cpu_re && !load_stall && !fwd;
    assign store_stall = bus.cpu_we && full_q;
    // A stalled load holds the whole request, so its paired store must wait too.
    assign enq         = !reset && bus.cpu_we && !full_q && !load_stall;
    assign drain       = !reset && !empty_q && !load_port;

    assign bus.stall     = load_stall || store_stall;
    assign bus.cpu_rdata = bus.stall ? '0 : (fwd ? hit_data : bus.mem_rdata);
    assign bus.mem_we    = drain;
    assign bus.mem_addr  = drain ? addr_q[head] : bus.cpu_addr;
    assign bus.mem_wdata = drain ? data_q[head] : '0;

    assign count = reset ? '0 : cnt;
    assign empty = reset || empty_q;
    assign full  = !reset && full_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
            case ({enq, drain})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail] <= bus.cpu_addr;
            data_q[tail] <= bus.cpu_wdata;
        end
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the processor's memory stage and the single-port data memory. Stores are accepted in one cycle and written to memory later in FIFO order, during cycles when the memory port is not needed by a load. Loads take the port combinationally, as the data memory already behaves. Pending stores are checked on every load, so a load never returns stale data.

## Interface
- `DEPTH`, 4, number of store entries; power of two, ≥2
- `AW`, 16, address width
- `DW`, 16, data width
- `clk` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-high; one clock, and reset is synchronous and active-high
- `cpu_we` in 1: store request this cycle
- `cpu_re` in 1: load request this cycle
- `cpu_addr` in AW: load/store address
- `cpu_wdata` in DW: store data
- `cpu_rdata` out DW: load result, combinational, same cycle
- `stall` out 1: request not completed this cycle; processor holds the request and retries
- `mem_addr` out AW: data-memory address
- `mem_wdata` out DW: data-memory write data
- `mem_we` out 1: data-memory write enable; memory writes on the clk edge
- `mem_rdata` in DW: data-memory combinational read data
- `count` out $clog2(DEPTH+1): number of occupied entries
- `empty` out 1: count==0
- `full` out 1: count==DEPTH

## Operation
- Storage is a circular FIFO of {addr, data} entries with head and tail pointers. Pointers wrap modulo DEPTH.
- **Port arbitration**, evaluated combinationally each cycle:
  - LOAD: `cpu_re` && !full && no unresolved hazard. Sets mem_addr=cpu_addr and mem_we=0.
  - DRAIN: otherwise, if !empty. Sets mem_addr=head.addr, mem_wdata=head.data, mem_we=1. Head advances at the edge.
  - IDLE: otherwise. Sets mem_we=0, mem_addr=cpu_addr, and mem_wdata=0.
- **Store accept:** `cpu_we` && !full enqueues {cpu_addr, cpu_wdata} at the tail at the edge.
  - `cpu_we` && full asserts stall, and nothing is enqueued.
  - Full forces DRAIN, so the next cycle always has space.
- **Load match:** the load address is compared against all occupied entries.
  - With no match, cpu_rdata=mem_rdata.
  - A match is resolved per the configuration below.
- A load while full with no forward hit asserts stall, and the port drains.
- **Simultaneous `cpu_re` and `cpu_we`:** the load is served first and sees the buffer and memory contents before this store. The store is enqueued at the same edge.
- **Simultaneous enqueue and drain:** count is unchanged, and both pointers advance.
- When stall=1 for a load, cpu_rdata=0.

## Timing
- Store latency to the processor is 0 cycles: the store is accepted at the edge.
- Store latency to memory is at least 1 edge. An empty buffer with no load drains the entry on the cycle after the enqueue edge.
- Load latency is 0 cycles: the result is combinational in the request cycle, unless stall=1.
- Stores are written to memory in strict program order. Later stores to the same address overwrite earlier ones.
- Reset, at the edge with reset=1:
  - head=tail=0, count=0, empty=1, full=0.
  - Pending stores are discarded.
  - A reset cycle also suppresses enqueue and drain; mem_we=0 during reset.
- Outputs after reset, with no requests: stall=0, mem_we=0, cpu_rdata=mem_rdata.
- **Starvation bound:** back-to-back loads may block drain indefinitely only while !full. A full buffer drains every cycle until it is not full.

## Configuration
- `STORE_BUF_FWD_EN` defined:
  - A matching load returns the data of the youngest matching entry. stall=0, and the port may DRAIN in the same cycle.
  - A load forward-hit while full is also served without stall.
- `STORE_BUF_FWD_EN` undefined:
  - A matching load asserts stall, and the port is given to DRAIN.
  - The load repeats each cycle until no entry matches. It then proceeds as a normal LOAD.
  - Worst case, the load waits until every entry up to and including the youngest match has drained.

## Test plan
- **Reset then single store:** reset 1 cycle, then store addr 0x0010 data 0xBEEF.
  - Next cycle: mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF.
  - Then count returns to 0 and memory[0x10]=0xBEEF.
- **Fill while loading:** 4 stores to 0x20..0x23 interleaved with loads to 0x40.
  - No drain occurs while loads are present. full=1 after the 4th store.
  - A 5th store asserts stall for exactly 1 cycle and is accepted the next cycle.
  - Final memory order is correct.
- **Forward (FWD_EN):** store 0x30←0x1111, then store 0x30←0x2222, then load 0x30 while both are pending.
  - cpu_rdata=0x2222, stall=0.
- **No forward:** the same sequence without the macro.
  - stall=1 for 2 cycles while both entries drain.
  - The load then returns 0x2222 from memory.
- **Same-cycle load and store to 0x50:** memory holds 0x0000.
  - cpu_rdata=0x0000, and the store is enqueued.
  - A following load returns 0x5555, the stored value, via forward or stall.
- **Reset mid-operation:** 3 entries pending, reset asserted 1 cycle.
  - count=0, empty=1, mem_we=0 in that cycle.
  - No discarded store ever reaches memory.
